// File: rtl/msrv_32_imm_pkg.sv
// Shared immediate-type codes and major opcode constants for the immediate generator and instruction encoder.
package msrv_32_imm_pkg;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_I_ALT = 3'b001;
    localparam logic [2:0] IMM_S     = 3'b010;
    localparam logic [2:0] IMM_B     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_J     = 3'b101;
    localparam logic [2:0] IMM_CSR   = 3'b110;
    localparam logic [2:0] IMM_I_X   = 3'b111;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

endpackage

// File: rtl/msrv_32_imm_range_chk.sv
// Flags an immediate whose natural value cannot be represented by the selected instruction format.
module msrv_32_imm_range_chk
    import msrv_32_imm_pkg::*;
(
    input  logic [31:0] imm,
    input  logic [2:0]  imm_type,
    output logic        err
);

    // A signed field of width N+1 fits when all bits from N upward agree.
    logic ext_11_ok;
    logic ext_12_ok;
    logic ext_20_ok;

    assign ext_11_ok = (&imm[31:11]) || !(|imm[31:11]);
    assign ext_12_ok = (&imm[31:12]) || !(|imm[31:12]);
    assign ext_20_ok = (&imm[31:20]) || !(|imm[31:20]);

    always_comb begin
        err = 1'b0;
        case (imm_type)
            IMM_S:   err = !ext_11_ok;
            IMM_B:   err = !ext_12_ok || imm[0];
            IMM_U:   err = |imm[11:0];
            IMM_J:   err = !ext_20_ok || imm[0];
            IMM_CSR: err = |imm[31:5];
            default: err = !ext_11_ok;
        endcase
    end

endmodule

// File: rtl/msrv_32_instr_encoder.sv
// Packs RV32I fields and a natural immediate into an instruction word behind a one-deep valid/ready register.
// Immediate range checking is built only when MSRV_IMM_RANGE_CHECK_EN is defined.
module msrv_32_instr_encoder
    import msrv_32_imm_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic [6:0]         opcode_in,
    input  logic [4:0]         rd_in,
    input  logic [2:0]         funct3_in,
    input  logic [4:0]         rs1_in,
    input  logic [4:0]         rs2_in,
    input  logic [6:0]         funct7_in,
    input  logic [31:0]        imm_in,
    input  logic [2:0]         imm_type_in,
    input  logic               clear_in,
    output logic               valid_out,
    input  logic               ready_in,
    output logic [31:0]        instr_out,
    output logic               imm_err_out,
    output logic               err_sticky_out,
    output logic [COUNT_W-1:0] count_out
);

    // Handshake: a word moves on a side when valid and ready are both high at
    // the rising edge; the output word stays frozen while valid_out && !ready_in.
    logic               in_hs;
    logic               out_hs;
    logic               valid_q;
    logic [31:0]        instr_q;
    logic [31:0]        enc_word;
    logic [COUNT_W-1:0] count_q;

    assign ready_out = !valid_q || ready_in;
    assign in_hs     = valid_in && ready_out;
    assign out_hs    = valid_q && ready_in;

    always_comb begin
        enc_word = {imm_in[11:0], rs1_in, funct3_in, rd_in, opcode_in};
        case (imm_type_in)
            IMM_S:   enc_word = {imm_in[11:5], rs2_in, rs1_in, funct3_in, imm_in[4:0], opcode_in};
            IMM_B:   enc_word = {imm_in[12], imm_in[10:5], rs2_in, rs1_in, funct3_in,
                                 imm_in[4:1], imm_in[11], opcode_in};
            IMM_U:   enc_word = {imm_in[31:12], rd_in, opcode_in};
            IMM_J:   enc_word = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], rd_in, opcode_in};
            IMM_CSR: enc_word = {funct7_in, rs2_in, imm_in[4:0], funct3_in, rd_in, opcode_in};
            default: enc_word = {imm_in[11:0], rs1_in, funct3_in, rd_in, opcode_in};
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
        end else if (in_hs) begin
            valid_q <= 1'b1;
            instr_q <= enc_word;
        end else if (out_hs) begin
            valid_q <= 1'b0;
        end
    end

    // Clear wins over a same-cycle handshake; the count sticks at all-ones.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
        end else if (clear_in) begin
            count_q <= '0;
        end else if (out_hs && (count_q != {COUNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

`ifdef MSRV_IMM_RANGE_CHECK_EN
    logic enc_err;
    logic err_q;
    logic sticky_q;

    msrv_32_imm_range_chk u_range_chk (
        .imm      (imm_in),
        .imm_type (imm_type_in),
        .err      (enc_err)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (in_hs) begin
                err_q <= enc_err;
            end
            if (clear_in) begin
                sticky_q <= 1'b0;
            end else if (out_hs) begin
                sticky_q <= sticky_q | err_q;
            end
        end
    end

    assign imm_err_out    = err_q;
    assign err_sticky_out = sticky_q;
`else
    assign imm_err_out    = 1'b0;
    assign err_sticky_out = 1'b0;
`endif

    assign valid_out = valid_q;
    assign instr_out = instr_q;
    assign count_out = count_q;

endmodule

// File: tb/tb_msrv_32_instr_encoder.sv
// Self-checking bench for msrv_32_instr_encoder: directed vectors, range flags, backpressure, reset, saturation, random traffic.
`timescale 1ns/1ps
module tb_msrv_32_instr_encoder;
    import msrv_32_imm_pkg::*;

`ifdef MSRV_IMM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic [31:0] exp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n_in = 1'b0;
    always #5 clk = ~clk;

    logic        valid_in = 1'b0, ready_in = 1'b0, clear_in = 1'b0;
    logic [6:0]  opcode_in = '0, funct7_in = '0;
    logic [4:0]  rd_in = '0, rs1_in = '0, rs2_in = '0;
    logic [2:0]  funct3_in = '0, imm_type_in = '0;
    logic [31:0] imm_in = '0;

    logic        ready_out, valid_out, imm_err_out, err_sticky_out;
    logic [31:0] instr_out;
    logic [15:0] count_out;
    logic        sat_ready, sat_valid, sat_err, sat_sticky;
    logic [31:0] sat_instr;
    logic [1:0]  sat_count;

    msrv_32_instr_encoder #(.COUNT_W(16)) dut (
        .clk_in(clk), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(ready_out),
        .opcode_in(opcode_in), .rd_in(rd_in), .funct3_in(funct3_in), .rs1_in(rs1_in),
        .rs2_in(rs2_in), .funct7_in(funct7_in), .imm_in(imm_in), .imm_type_in(imm_type_in),
        .clear_in(clear_in), .valid_out(valid_out), .ready_in(ready_in), .instr_out(instr_out),
        .imm_err_out(imm_err_out), .err_sticky_out(err_sticky_out), .count_out(count_out)
    );

    msrv_32_instr_encoder #(.COUNT_W(2)) dut_sat (
        .clk_in(clk), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(sat_ready),
        .opcode_in(opcode_in), .rd_in(rd_in), .funct3_in(funct3_in), .rs1_in(rs1_in),
        .rs2_in(rs2_in), .funct7_in(funct7_in), .imm_in(imm_in), .imm_type_in(imm_type_in),
        .clear_in(clear_in), .valid_out(sat_valid), .ready_in(ready_in), .instr_out(sat_instr),
        .imm_err_out(sat_err), .err_sticky_out(sat_sticky), .count_out(sat_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    // Result is {err, word}; the range rule is expressed as numeric intervals.
    function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [6:0] f7,
                                          input logic [31:0] imm, input logic [2:0] typ);
        logic [31:0] w;
        logic [31:0] u_op, u_rd, u_f3, u_rs1, u_rs2, u_csr;
        int          s;
        bit          bad;
        s     = $signed(imm);
        u_op  = 32'(op);
        u_rd  = 32'(rd) << 7;
        u_f3  = 32'(f3) << 12;
        u_rs1 = 32'(rs1) << 15;
        u_rs2 = 32'(rs2) << 20;
        u_csr = ((32'(f7) << 5) | 32'(rs2)) << 20;
        case (typ)
            3'd2: begin
                w   = ((imm >> 5) & 32'h7F) << 25 | u_rs2 | u_rs1 | u_f3 | ((imm & 32'h1F) << 7) | u_op;
                bad = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                w   = ((imm >> 12) & 32'h1) << 31 | ((imm >> 5) & 32'h3F) << 25 | u_rs2 | u_rs1 | u_f3
                      | ((imm >> 1) & 32'hF) << 8 | ((imm >> 11) & 32'h1) << 7 | u_op;
                bad = (s < -4096) || (s > 4095) || (imm % 2 != 0);
            end
            3'd4: begin
                w   = (imm & 32'hFFFFF000) | u_rd | u_op;
                bad = (imm % 4096) != 0;
            end
            3'd5: begin
                w   = ((imm >> 20) & 32'h1) << 31 | ((imm >> 1) & 32'h3FF) << 21
                      | ((imm >> 11) & 32'h1) << 20 | (imm & 32'h000FF000) | u_rd | u_op;
                bad = (s < -1048576) || (s > 1048575) || (imm % 2 != 0);
            end
            3'd6: begin
                w   = u_csr | ((imm & 32'h1F) << 15) | u_f3 | u_rd | u_op;
                bad = imm >= 32;
            end
            default: begin
                w   = ((imm & 32'hFFF) << 20) | u_rs1 | u_f3 | u_rd | u_op;
                bad = (s < -2048) || (s > 2047);
            end
        endcase
        return {RANGE_EN && bad, w};
    endfunction

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    int          exp_count  = 0;
    logic        exp_sticky = 1'b0;

    // Inputs only change on the falling edge; this looks at them 2 ns later and
    // predicts what the next rising edge will do.
    always @(negedge clk) begin
        logic [32:0] e;
        bit          in_hs, out_hs;
        #2;
        if (!rst_n_in) begin
            exp_q.delete();
            exp_count  = 0;
            exp_sticky = 1'b0;
        end else begin
            n_tests++;
            if (valid_out !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL sb_valid: got %b expected %b at %0t", valid_out, exp_q.size() != 0, $time);
            end
            out_hs = (exp_q.size() != 0) && ready_in;
            in_hs  = valid_in && ((exp_q.size() == 0) || ready_in);
            e      = '0;
            if (out_hs) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({imm_err_out, instr_out} !== e || {sat_err, sat_instr} !== e) begin
                    n_fail++;
                    $display("FAIL sb_word: got err=%b instr=%h (sat %b/%h) expected err=%b instr=%h",
                             imm_err_out, instr_out, sat_err, sat_instr, e[32], e[31:0]);
                end
            end
            if (clear_in) begin
                exp_count  = 0;
                exp_sticky = 1'b0;
            end else if (out_hs) begin
                if (exp_count < 65535) exp_count++;
                exp_sticky = exp_sticky | e[32];
            end
            if (in_hs)
                exp_q.push_back(model(opcode_in, rd_in, funct3_in, rs1_in, rs2_in, funct7_in, imm_in, imm_type_in));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_vec(input vec_t v);
        opcode_in = v.op; rd_in = v.rd; funct3_in = v.f3; rs1_in = v.rs1;
        rs2_in = v.rs2; funct7_in = v.f7; imm_in = v.imm; imm_type_in = v.typ;
    endtask

    task automatic drive_rand();
        opcode_in = 7'($urandom); rd_in = 5'($urandom); funct3_in = 3'($urandom);
        rs1_in = 5'($urandom); rs2_in = 5'($urandom); funct7_in = 7'($urandom);
        imm_type_in = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0: imm_in = $urandom;
            1: imm_in = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: imm_in = $urandom & 32'hFFFFF000;
            default: imm_in = 32'($urandom_range(0, 63));
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_in = 1'b0; ready_in = 1'b1; clear_in = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n_in = 1'b0; ready_in = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        n_tests += 6;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", valid_out); end
        if (instr_out !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h expected 0", instr_out); end
        if (imm_err_out !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", imm_err_out); end
        if (err_sticky_out !== 1'b0) begin n_fail++; $display("FAIL rst_sticky: got %b expected 0", err_sticky_out); end
        if (count_out !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count_out); end
        if (ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", ready_out); end
        @(negedge clk);
        rst_n_in = 1'b1;
    endtask

    task automatic test_encode();
        vec_t tab[5];
        tab[0] = '{OPC_OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF, IMM_I,   32'hFFF00093};
        tab[1] = '{OPC_STORE,  5'd0, 3'd2, 5'd3, 5'd2, 7'd0, 32'd8,        IMM_S,   32'h0021A423};
        tab[2] = '{OPC_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFC, IMM_B,   32'hFE000EE3};
        tab[3] = '{OPC_JAL,    5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h800,      IMM_J,   32'h001000EF};
        tab[4] = '{OPC_SYSTEM, 5'd5, 3'd5, 5'd0, 5'd0, 7'h18, 32'd3,       IMM_CSR, 32'h3001D2F3};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_vec(tab[i]); valid_in = 1'b1; ready_in = 1'b1;
            @(negedge clk);
            valid_in = 1'b0;
            #3;
            n_tests += 2;
            if (instr_out !== tab[i].exp || valid_out !== 1'b1) begin
                n_fail++;
                $display("FAIL encode_%0d: got %h valid=%b expected %h valid=1", i, instr_out, valid_out, tab[i].exp);
            end
            if (imm_err_out !== 1'b0) begin
                n_fail++; $display("FAIL encode_err_%0d: got %b expected 0", i, imm_err_out);
            end
        end
        idle(1);
    endtask

    task automatic test_range();
        vec_t tab[4];
        // exp[0] is 1 for an out-of-range immediate
        tab[0] = '{OPC_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd6,     IMM_B, 32'd0};
        tab[1] = '{OPC_OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h800,   IMM_I, 32'd1};
        tab[2] = '{OPC_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3,     IMM_B, 32'd1};
        tab[3] = '{OPC_LUI,    5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'h123,   IMM_U, 32'd1};
        @(negedge clk);
        clear_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_vec(tab[i]); valid_in = 1'b1;
            @(negedge clk);
            valid_in = 1'b0;
            #3;
            n_tests++;
            if (imm_err_out !== (RANGE_EN && tab[i].exp[0])) begin
                n_fail++;
                $display("FAIL range_err_%0d: got %b expected %b", i, imm_err_out, RANGE_EN && tab[i].exp[0]);
            end
            @(negedge clk);
            #3;
            n_tests++;
            if (err_sticky_out !== (RANGE_EN && i >= 1)) begin
                n_fail++;
                $display("FAIL range_sticky_%0d: got %b expected %b", i, err_sticky_out, RANGE_EN && i >= 1);
            end
        end
        @(negedge clk);
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        #3;
        n_tests += 2;
        if (err_sticky_out !== 1'b0) begin n_fail++; $display("FAIL clear_sticky: got %b expected 0", err_sticky_out); end
        if (count_out !== 16'd0) begin n_fail++; $display("FAIL clear_count: got %0d expected 0", count_out); end
    endtask

    task automatic test_back_to_back();
        logic [32:0] held;
        int          base;
        idle(2);
        #3;
        base = exp_count;
        @(negedge clk);
        drive_rand(); valid_in = 1'b1; ready_in = 1'b0;
        held = model(opcode_in, rd_in, funct3_in, rs1_in, rs2_in, funct7_in, imm_in, imm_type_in);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_rand();
            #3;
            n_tests += 3;
            if (instr_out !== held[31:0] || imm_err_out !== held[32]) begin
                n_fail++; $display("FAIL stall_word_%0d: got %b/%h expected %b/%h", i, imm_err_out, instr_out, held[32], held[31:0]);
            end
            if (ready_out !== 1'b0) begin n_fail++; $display("FAIL stall_ready_%0d: got %b expected 0", i, ready_out); end
            if (32'(count_out) !== 32'(base)) begin n_fail++; $display("FAIL stall_count_%0d: got %0d expected %0d", i, count_out, base); end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive_rand(); valid_in = 1'b1; ready_in = 1'b1;
            #3;
            n_tests += 2;
            if (32'(count_out) !== 32'(base + k)) begin
                n_fail++; $display("FAIL b2b_count_%0d: got %0d expected %0d", k, count_out, base + k);
            end
            if (ready_out !== 1'b1 || valid_out !== 1'b1) begin
                n_fail++; $display("FAIL b2b_flow_%0d: got ready=%b valid=%b expected 1/1", k, ready_out, valid_out);
            end
        end
        idle(2);
    endtask

    task automatic test_clear_same_cycle();
        @(negedge clk);
        drive_rand(); valid_in = 1'b1; ready_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0; clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        #3;
        n_tests += 2;
        if (count_out !== 16'd0) begin n_fail++; $display("FAIL clear_hs_count: got %0d expected 0", count_out); end
        if (err_sticky_out !== 1'b0) begin n_fail++; $display("FAIL clear_hs_sticky: got %b expected 0", err_sticky_out); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        clear_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_rand(); valid_in = 1'b1;
        end
        idle(2);
        #3;
        n_tests += 4;
        if (sat_count !== 2'd3) begin n_fail++; $display("FAIL sat_count: got %0d expected 3", sat_count); end
        if (32'(count_out) !== 32'(exp_count) || exp_count != 5) begin
            n_fail++; $display("FAIL sat_wide_count: got %0d expected 5 (model %0d)", count_out, exp_count);
        end
        if (sat_valid !== 1'b0 || sat_ready !== 1'b1) begin
            n_fail++; $display("FAIL sat_flow: got valid=%b ready=%b expected 0/1", sat_valid, sat_ready);
        end
        if (sat_sticky !== exp_sticky) begin n_fail++; $display("FAIL sat_sticky: got %b expected %b", sat_sticky, exp_sticky); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive_rand(); valid_in = 1'b1; ready_in = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
        #3;
        n_tests++;
        if (valid_out !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b expected 1", valid_out); end
        rst_n_in = 1'b0;
        #1;
        n_tests += 3;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", valid_out); end
        if (instr_out !== 32'h0) begin n_fail++; $display("FAIL arst_instr: got %h expected 0", instr_out); end
        if (count_out !== 16'd0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", count_out); end
        exp_q.delete();
        exp_count  = 0;
        exp_sticky = 1'b0;
        @(negedge clk);
        rst_n_in = 1'b1; ready_in = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive_rand();
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = ($urandom_range(0, 2) != 0);
            clear_in = ($urandom_range(0, 40) == 0);
        end
        idle(3);
        #3;
        n_tests += 4;
        if (32'(count_out) !== 32'(exp_count)) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", count_out, exp_count); end
        if (32'(sat_count) !== ((exp_count > 3) ? 32'd3 : 32'(exp_count))) begin
            n_fail++; $display("FAIL rand_sat_count: got %0d expected %0d", sat_count, (exp_count > 3) ? 3 : exp_count);
        end
        if (err_sticky_out !== exp_sticky) begin n_fail++; $display("FAIL rand_sticky: got %b expected %b", err_sticky_out, exp_sticky); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_encode();
        test_range();
        test_back_to_back();
        test_clear_same_cycle();
        test_saturation();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
